uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter on the CPU device bus (valid/addr/wvalid/size/wdata -> rdata/ready/last).

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_mmio.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and register map for the memory-mapped UART TX.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic [7:0] TXDATA_OFS = 8'h00;
  localparam logic [7:0] STATUS_OFS = 8'h08;
  localparam logic [7:0] DIV_OFS    = 8'h10;

  // Three 8-byte registers make up the decoded window.
  localparam int unsigned c_window_bytes = 24;

  // A bit period below two cycles cannot be timed by the wrap counter.
  function automatic logic [13:0] clamp_div(input logic [13:0] d);
    return (d < 14'd2) ? 14'd2 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with show-ahead read port and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != c_full_count) || w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = (r_count == c_full_count);
  assign empty    = (r_count == '0);
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio
// Brief    : Memory-mapped UART transmitter with TX FIFO, runtime divisor,
//            configurable framing and a status register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_mmio import uart_pkg::*; #(
  parameter logic [13:0] CLK_DIV    = 14'd10416,
  parameter int          DATA_BITS  = 8,
  parameter logic        PARITY_EN  = 1'b0,
  parameter logic        PARITY_ODD = 1'b0,
  parameter int          STOP_BITS  = 1,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [63:0] addr,
  input  logic        wvalid,
  input  logic [7:0]  size,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        ready,
  output logic        last,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] c_last_data = 3'(DATA_BITS - 1);
  localparam logic [2:0] c_last_stop = 3'(STOP_BITS - 1);
  localparam logic [7:0] c_data_mask = 8'((1 << DATA_BITS) - 1);

  // Register decode
  logic [63:0] w_offset;
  logic        w_in_win;
  logic        w_sel_tx;
  logic        w_sel_stat;
  logic        w_sel_div;
  logic        w_push;
  logic [7:0]  w_push_byte;
  logic        w_unused_size;

  // FIFO
  logic        w_pop;
  logic [7:0]  w_fifo_data;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [AW:0] w_fifo_count;

  // Divisor and FSM datapath
  logic [13:0] r_div;
  uart_state_t r_state,     w_state_nxt;
  logic [7:0]  r_shift,     w_shift_nxt;
  logic [13:0] r_div_lat,   w_div_lat_nxt;
  logic [13:0] r_timer,     w_timer_nxt;
  logic [2:0]  r_bit_cnt,   w_bit_cnt_nxt;
  logic        r_par,       w_par_nxt;
  logic        w_load;
  logic        w_bit_end;
  logic        w_par_new;
  logic        w_line_idle;

  assign w_unused_size = ^size;

  assign w_offset   = addr - BASE_ADDR;
  assign w_in_win   = (w_offset < 64'(c_window_bytes));
  assign w_sel_tx   = w_in_win && (w_offset[4:3] == TXDATA_OFS[4:3]);
  assign w_sel_stat = w_in_win && (w_offset[4:3] == STATUS_OFS[4:3]);
  assign w_sel_div  = w_in_win && (w_offset[4:3] == DIV_OFS[4:3]);

  // A full-FIFO TXDATA write stalls until the FSM pops a slot this cycle.
  assign ready       = !(valid && wvalid && w_sel_tx && w_fifo_full && !w_pop);
  assign last        = ready;
  assign w_push      = valid && wvalid && w_sel_tx && ready;
  assign w_push_byte = wdata[{addr[2:0], 3'b000} +: 8];

  always_comb begin
    rdata = '0;
    if (w_sel_stat) begin
      rdata[15:0] = {8'(w_fifo_count), 5'b0, w_line_idle, w_fifo_full, w_fifo_empty};
    end else if (w_sel_div) begin
      rdata[13:0] = r_div;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= CLK_DIV;
    end else if (valid && wvalid && w_sel_div) begin
      r_div <= clamp_div(wdata[13:0]);
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_byte),
    .pop       (w_pop),
    .pop_data  (w_fifo_data),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign w_bit_end = (r_timer == (r_div_lat - 14'd1));
  assign w_par_new = (^(w_fifo_data & c_data_mask)) ^ PARITY_ODD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_div_lat <= CLK_DIV;
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_div_lat <= w_div_lat_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_par     <= w_par_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_div_lat_nxt = r_div_lat;
    w_bit_cnt_nxt = r_bit_cnt;
    w_par_nxt     = r_par;
    w_timer_nxt   = w_bit_end ? 14'd0 : (r_timer + 14'd1);
    w_load        = 1'b0;
    w_pop         = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_timer_nxt = '0;
        if (!w_fifo_empty) w_load = 1'b1;
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == c_last_data) begin
            w_state_nxt   = PARITY_EN ? PARITY : STOP;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt   = STOP;
          w_bit_cnt_nxt = '0;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt == c_last_stop) begin
            if (!w_fifo_empty) w_load = 1'b1;
            else               w_state_nxt = IDLE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // The divisor is sampled only here, so mid-frame writes wait for the next START.
    if (w_load) begin
      w_pop         = 1'b1;
      w_state_nxt   = START;
      w_shift_nxt   = w_fifo_data;
      w_div_lat_nxt = r_div;
      w_par_nxt     = w_par_new;
      w_timer_nxt   = '0;
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (r_state)
      START:   tx = 1'b0;
      DATA:    tx = r_shift[0];
      PARITY:  tx = r_par;
      default: tx = 1'b1;
    endcase
  end

  assign w_line_idle = (r_state == IDLE);
  assign busy        = !w_fifo_empty || !w_line_idle;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// Directed bench for uart_tx_mmio: scoreboard-driven serial decode on the 8N1
// instance plus parity/stop-bit and reset-abort checks on two framing variants.
module tb_uart_tx_mmio;

  localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
  localparam logic [63:0] A_TX  = BASE;
  localparam logic [63:0] A_ST  = BASE + 64'd8;
  localparam logic [63:0] A_DIV = BASE + 64'd16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_e;
  logic        rst_even;
  logic [2:0]  vld;
  logic        wvalid;
  logic [63:0] addr;
  logic [7:0]  size;
  logic [63:0] wdata;
  logic [63:0] rd0, rd1, rd2;
  logic [2:0]  rdy, lst, txl, bsy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mon_div  = 4;
  bit mon_on   = 1'b0;
  logic [7:0] exp_q[$];
  int         starts[$];

  assign rst_even = rst & rst_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_mmio #(.BASE_ADDR(BASE)) u_main (
    .clk(clk), .reset(rst), .valid(vld[0]), .addr(addr), .wvalid(wvalid), .size(size),
    .wdata(wdata), .rdata(rd0), .ready(rdy[0]), .last(lst[0]), .tx(txl[0]), .busy(bsy[0]));

  uart_tx_mmio #(.CLK_DIV(14'd4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2),
                 .BASE_ADDR(BASE)) u_odd (
    .clk(clk), .reset(rst), .valid(vld[1]), .addr(addr), .wvalid(wvalid), .size(size),
    .wdata(wdata), .rdata(rd1), .ready(rdy[1]), .last(lst[1]), .tx(txl[1]), .busy(bsy[1]));

  uart_tx_mmio #(.CLK_DIV(14'd4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1),
                 .BASE_ADDR(BASE)) u_even (
    .clk(clk), .reset(rst_even), .valid(vld[2]), .addr(addr), .wvalid(wvalid), .size(size),
    .wdata(wdata), .rdata(rd2), .ready(rdy[2]), .last(lst[2]), .tx(txl[2]), .busy(bsy[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd_of(input int w);
    return (w == 0) ? rd0 : (w == 1) ? rd1 : rd2;
  endfunction

  task automatic bus_write(input int w, input logic [63:0] a, input logic [63:0] d,
                           output int acc_cyc, output int stalls);
    @(negedge clk);
    vld = 3'b000; vld[w] = 1'b1; wvalid = 1'b1; addr = a; wdata = d; stalls = 0;
    #1;
    while (!rdy[w] && stalls < 2000) begin
      @(negedge clk); #1; stalls++;
    end
    acc_cyc = cyc;
    check("write_accepted", rdy[w], 1);
    @(posedge clk); #1;
    vld = 3'b000; wvalid = 1'b0;
  endtask

  task automatic bus_read(input int w, input logic [63:0] a, output logic [63:0] d,
                          output logic [1:0] rl);
    @(negedge clk);
    vld = 3'b000; vld[w] = 1'b1; wvalid = 1'b0; addr = a;
    #1;
    d  = rd_of(w);
    rl = {lst[w], rdy[w]};
    @(posedge clk); #1;
    vld = 3'b000;
  endtask

  task automatic send(input int w, input logic [7:0] b, input int lane,
                      output int acc_cyc, output int stalls);
    logic [63:0] d;
    d = {8{~b}};
    d[8*lane +: 8] = b;
    if (w == 0) exp_q.push_back(b);
    bus_write(w, A_TX + 64'(lane), d, acc_cyc, stalls);
  endtask

  task automatic wait_fall(input int w, output int n, output int c);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (txl[w] !== 1'b0 && n < 5000);
    c = cyc;
    check("start_bit_seen", txl[w], 0);
  endtask

  task automatic wait_idle(input int w, input int limit);
    int i;
    i = 0;
    while ((bsy[w] || exp_q.size() != 0) && i < limit) begin
      @(negedge clk); i++;
    end
    check("line_went_idle", bsy[w], 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic capture(input int w, input int nbits, input int d,
                         output logic [15:0] bits, output logic busy_last, output logic busy_after);
    int n, c;
    wait_fall(w, n, c);
    bits = '0;
    repeat (d / 2) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      bits[k] = txl[w];
      if (k < nbits - 1) repeat (d) @(negedge clk);
    end
    repeat (d - d / 2 - 1) @(negedge clk);
    busy_last = bsy[w];
    repeat (2) @(negedge clk);
    busy_after = bsy[w];
  endtask

  // Serial receiver for the 8N1 instance; compares each frame with the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on && rst && txl[0] === 1'b0) begin
        int d;
        logic [7:0] got;
        logic start_ok, stop_ok;
        d = mon_div;
        starts.push_back(cyc);
        repeat (d / 2) @(negedge clk);
        start_ok = (txl[0] === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clk);
          got[i] = txl[0];
        end
        repeat (d) @(negedge clk);
        stop_ok = (txl[0] === 1'b1);
        check("rx_frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rx_byte", {start_ok, stop_ok, got}, {2'b11, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rv;
    logic [1:0]  rl;
    int acc, st, n, c, s;
    logic [39:0] obs, exp40;
    logic [9:0]  fr;
    logic [15:0] bits;
    logic bl, ba, b39, b40, any_low;

    rst = 1'b0; rst_e = 1'b1; vld = 3'b000; wvalid = 1'b0; addr = '0; wdata = '0; size = 8'd3;
    repeat (3) @(negedge clk);
    check("reset_tx", txl, 3'b111);
    check("reset_busy", bsy, 3'b000);
    @(negedge clk); rst = 1'b1;
    mon_on = 1'b1;

    bus_read(0, A_ST, rv, rl);   check("status_reset", rv, 64'h5);
    check("read_ready_last", rl, 2'b11);
    bus_read(0, A_DIV, rv, rl);  check("div_reset", rv, 64'd10416);
    bus_read(0, A_TX, rv, rl);   check("txdata_reads_zero", rv, 0);
    bus_read(0, BASE + 64'h18, rv, rl); check("outside_window_rdata", rv, 0);
    check("outside_window_ready", rl, 2'b11);
    bus_write(0, A_ST, 64'hFF, acc, st);
    bus_read(0, A_ST, rv, rl);   check("status_write_ignored", rv, 64'h5);

    // 8N1 frame at 4 cycles per bit
    bus_write(0, A_DIV, 64'd4, acc, st);
    bus_read(0, A_DIV, rv, rl);  check("div_written", rv, 64'd4);
    send(0, 8'h41, 0, acc, st);
    wait_fall(0, n, c);
    check("push_to_start_latency", n, 2);
    fr = {1'b1, 8'h41, 1'b0};
    obs[0] = txl[0];
    for (int k = 1; k < 40; k++) begin
      @(negedge clk); obs[k] = txl[0];
    end
    b39 = bsy[0];
    @(negedge clk); b40 = bsy[0];
    for (int k = 0; k < 40; k++) exp40[k] = fr[k / 4];
    check("frame_0x41_waveform", obs, exp40);
    check("busy_last_stop_cycle", b39, 1);
    check("busy_after_frame", b40, 0);
    wait_idle(0, 100);

    // Fill the FIFO behind an active frame, then stall on the 17th write
    send(0, 8'h55, 0, acc, st);
    wait_fall(0, n, s);
    bus_read(0, A_ST, rv, rl);   check("status_sending_empty", rv, 64'h1);
    for (int i = 0; i < 16; i++) send(0, 8'h60 + 8'(i), i % 8, acc, st);
    bus_read(0, A_ST, rv, rl);   check("status_full", rv, 64'h1002);
    send(0, 8'h7E, 3, acc, st);
    check("full_write_stalled", st > 0, 1);
    check("full_write_accept_cycle", acc, s + 39);
    bus_read(0, A_ST, rv, rl);   check("status_full_after_push_pop", rv, 64'h1002);
    wait_idle(0, 18 * 40 + 100);

    // Divisor change mid-frame applies from the next frame
    starts.delete();
    send(0, 8'h3C, 1, acc, st);
    send(0, 8'hC3, 2, acc, st);
    bus_write(0, A_DIV, 64'd8, acc, st);
    mon_div = 8;
    send(0, 8'h96, 5, acc, st);
    for (int i = 0; i < 400 && starts.size() < 3; i++) @(negedge clk);
    check("three_frames_started", starts.size(), 3);
    check("frame1_len_div4", starts[1] - starts[0], 40);
    check("frame2_len_div8", starts[2] - starts[1], 80);
    wait_idle(0, 200);
    bus_write(0, A_DIV, 64'd0, acc, st);
    bus_read(0, A_DIV, rv, rl);  check("div_clamp_zero", rv, 64'd2);
    bus_write(0, A_DIV, 64'd1, acc, st);
    bus_read(0, A_DIV, rv, rl);  check("div_clamp_one", rv, 64'd2);

    // Odd parity, two stop bits
    send(1, 8'h03, 0, acc, st);
    capture(1, 12, 4, bits, bl, ba);
    check("odd_parity_frame", bits, 16'h0E06);
    check("two_stop_busy_in_stop2", bl, 1);
    check("two_stop_busy_after", ba, 0);

    // Even parity, one stop bit
    send(2, 8'h07, 0, acc, st);
    capture(2, 11, 4, bits, bl, ba);
    check("even_parity_frame", bits, 16'h060E);
    check("one_stop_busy_after", ba, 0);

    // Reset in the middle of the data bits aborts the frame
    send(2, 8'hA5, 0, acc, st);
    wait_fall(2, n, c);
    repeat (9) @(negedge clk);
    check("mid_data_tx_low_bit", txl[2], 1'b0);
    rst_e = 1'b0;
    #1;
    check("reset_abort_tx", txl[2], 1);
    check("reset_abort_busy", bsy[2], 0);
    @(negedge clk); rst_e = 1'b1;
    bus_read(2, A_ST, rv, rl);   check("status_after_abort", rv, 64'h5);
    any_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txl[2] !== 1'b1) any_low = 1'b1;
    end
    check("no_resumed_frame", any_low, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
